// File: rtl/fpga_sdpram_pkg.sv
// Shared types and helpers for the SDPRAM read-stream controller.
// Covers the FSM state encoding, count-width sizing and parameter legality.
package fpga_sdpram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } rd_state_e;

  localparam int unsigned DefReadLaten = 1;
  localparam int unsigned DefSkidDepth = DefReadLaten + 1;
  localparam int unsigned CntWidth     = $clog2(DefSkidDepth + 1);

  // Width needed to hold a count of 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit params_ok(input int unsigned read_laten,
                                   input int unsigned skid_depth);
    return (read_laten >= 1) && (read_laten <= 4) && (skid_depth >= read_laten + 1);
  endfunction

endpackage

// File: rtl/fpga_sync_fifo_skid.sv
// Small register-based skid FIFO with push/pop/count and a synchronous flush.
// Read data is the head entry straight from the storage registers.
module fpga_sync_fifo_skid #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fpga_sdpram_rd_stream.sv
// Burst read controller for the SDPRAM read port: issues reads, tracks latency,
// streams words out via a skid FIFO. Optional abort input: FPGA_SDPRAM_RD_STREAM_ABORT_EN.
module fpga_sdpram_rd_stream
  import fpga_sdpram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned READ_LATEN = 1,
  parameter int unsigned SKID_DEPTH = READ_LATEN + 1,
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  ram_rd,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_doutb,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
`ifdef FPGA_SDPRAM_RD_STREAM_ABORT_EN
  ,
  input  logic                  abort
`endif
);

  localparam int unsigned CNT_W = cnt_width(SKID_DEPTH);
  localparam int unsigned OCC_W = CNT_W + 1;

  if (!params_ok(READ_LATEN, SKID_DEPTH)) begin : g_param_err
    $error("fpga_sdpram_rd_stream: need 1<=READ_LATEN<=4 and SKID_DEPTH>=READ_LATEN+1");
  end

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]      outst_q, outst_d;
  logic [READ_LATEN-1:0] iss_q, iss_d, lst_q, lst_d;
  logic                  abort_q, abort_d;

  logic                  abort_act, pop, can_issue, ret, push;
  logic [OCC_W-1:0]      occ;
  logic [CNT_W-1:0]      fifo_cnt;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   fifo_rdata;

`ifdef FPGA_SDPRAM_RD_STREAM_ABORT_EN
  assign abort_act = abort && ((state_q == StRun) || (state_q == StDrain));
`else
  assign abort_act = 1'b0;
`endif

  assign pop = m_valid && m_ready;
  // Reserve FIFO space for every read in flight, crediting a word leaving this cycle.
  assign occ       = OCC_W'(outst_q) + OCC_W'(fifo_cnt) - OCC_W'(pop);
  assign can_issue = (state_q == StRun) && (rem_q != '0) &&
                     (occ < OCC_W'(SKID_DEPTH)) && !abort_act;
  assign ret  = iss_q[READ_LATEN-1];
  assign push = ret && !abort_q && !abort_act;

  fpga_sync_fifo_skid #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (SKID_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort_act),
    .push  (push),
    .wdata ({lst_q[READ_LATEN-1], ram_doutb}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_cnt),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      outst_q <= '0;
      iss_q   <= '0;
      lst_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      outst_q <= outst_d;
      iss_q   <= iss_d;
      lst_q   <= lst_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // Zero-length bursts take the DRAIN path; its exit condition already holds.
        if (cmd_valid) state_d = (cmd_len == '0) ? StDrain : StRun;
      end
      StRun: begin
        if (abort_act || (can_issue && (rem_q == LEN_WIDTH'(1)))) state_d = StDrain;
      end
      StDrain: begin
        if (abort_q || abort_act) begin
          if (outst_q == '0) state_d = StDone;
        end else if ((outst_q == '0) &&
                     (fifo_empty || ((fifo_cnt == CNT_W'(1)) && pop))) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    rem_d    = rem_q;
    abort_d  = abort_q;
    outst_d  = outst_q + CNT_W'(can_issue) - CNT_W'(ret);
    iss_d    = iss_q << 1;
    iss_d[0] = can_issue;
    lst_d    = lst_q << 1;
    lst_d[0] = (rem_q == LEN_WIDTH'(1));
    if ((state_q == StIdle) && cmd_valid) begin
      addr_d = cmd_addr;
      rem_d  = cmd_len;
    end else if (can_issue) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
      rem_d  = rem_q - LEN_WIDTH'(1);
    end
    if (abort_act) abort_d = 1'b1;
    else if (state_q == StDone) abort_d = 1'b0;
  end

  always_comb begin
    cmd_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    ram_rd    = can_issue;
    ram_addrb = addr_q;
    m_valid   = !fifo_empty;
    m_data    = fifo_rdata[DATA_WIDTH-1:0];
    // Head storage keeps stale entries once drained; only flag last on a live word.
    m_last    = !fifo_empty && fifo_rdata[DATA_WIDTH];
  end

endmodule

// File: tb/tb_fpga_sdpram_rd_stream.sv
// Directed bench: two controllers (read latency 1 and 3) share commands and m_ready,
// each fed by its own RAM model holding mem[i] = i.
module tb_fpga_sdpram_rd_stream;

  localparam int AW = 6;
  localparam int DW = 6;
  localparam int LW = 7;

  logic clk = 1'b0;
  logic rst_n;
  logic cmd_valid;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic m_ready;
`ifdef FPGA_SDPRAM_RD_STREAM_ABORT_EN
  logic abort;
`endif

  logic [1:0] cmd_ready, ram_rd, m_valid, m_last, busy, done;
  logic [1:0][AW-1:0] ram_addrb;
  logic [1:0][DW-1:0] m_data;
  logic [DW-1:0] dout0, p0, p1, dout1;
  logic [DW-1:0] mem [64];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fpga_sdpram_rd_stream #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .READ_LATEN (1), .SKID_DEPTH (2), .LEN_WIDTH (LW)
  ) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready[0]),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .ram_rd    (ram_rd[0]),
    .ram_addrb (ram_addrb[0]),
    .ram_doutb (dout0),
    .m_valid   (m_valid[0]),
    .m_ready   (m_ready),
    .m_data    (m_data[0]),
    .m_last    (m_last[0]),
    .busy      (busy[0]),
    .done      (done[0])
`ifdef FPGA_SDPRAM_RD_STREAM_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  fpga_sdpram_rd_stream #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .READ_LATEN (3), .SKID_DEPTH (4), .LEN_WIDTH (LW)
  ) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready[1]),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .ram_rd    (ram_rd[1]),
    .ram_addrb (ram_addrb[1]),
    .ram_doutb (dout1),
    .m_valid   (m_valid[1]),
    .m_ready   (m_ready),
    .m_data    (m_data[1]),
    .m_last    (m_last[1]),
    .busy      (busy[1]),
    .done      (done[1])
`ifdef FPGA_SDPRAM_RD_STREAM_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  // RAM models: latency 1 (enabled register) and latency 3 (free-running pipeline).
  always_ff @(posedge clk) begin
    if (ram_rd[0]) dout0 <= mem[ram_addrb[0]];
    p0    <= mem[ram_addrb[1]];
    p1    <= p0;
    dout1 <= p1;
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_cmd_ready"}, cmd_ready[d], 1);
      check({tag, "_ram_rd"},    ram_rd[d],    0);
      check({tag, "_ram_addrb"}, ram_addrb[d], 0);
      check({tag, "_m_valid"},   m_valid[d],   0);
      check({tag, "_m_data"},    m_data[d],    0);
      check({tag, "_m_last"},    m_last[d],    0);
      check({tag, "_busy"},      busy[d],      0);
      check({tag, "_done"},      done[d],      0);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    int            len;
    logic [15:0]   rdy;
    int            first;  // expected first word
    int            last;   // expected final word
  } burst_t;

  task automatic run_burst(input burst_t b);
    int k[2], iss[2], pops[2], fv[2], lhs[2], dc[2], nd[2], occ_max[2];
    int first_d[2], last_d[2];
    bit fin;
    for (int d = 0; d < 2; d++) begin
      k[d] = 0; iss[d] = 0; pops[d] = 0; fv[d] = -1; lhs[d] = -1; dc[d] = -1;
      nd[d] = 0; occ_max[d] = 0; first_d[d] = -1; last_d[d] = -1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = b.addr; cmd_len = LW'(b.len); m_ready = b.rdy[0];
    @(negedge clk);
    for (int d = 0; d < 2; d++) check("cmd_ready_at_accept", cmd_ready[d], 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    fin = 1'b0;
    for (int c = 1; c < 400 && !fin; c++) begin
      m_ready = b.rdy[c % 16];
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (c == 1) check("busy_after_accept", busy[d], 1);
        if (ram_rd[d]) begin
          check("issue_addr", ram_addrb[d], (b.addr + iss[d]) % 64);
          iss[d]++;
        end
        if (m_valid[d] && fv[d] < 0) fv[d] = c;
        if (m_valid[d] && m_ready) begin
          check("m_data", m_data[d], (b.addr + k[d]) % 64);
          check("m_last", m_last[d], k[d] == b.len - 1);
          if (k[d] == 0) first_d[d] = int'(m_data[d]);
          if (k[d] == b.len - 1) begin
            lhs[d] = c;
            last_d[d] = int'(m_data[d]);
          end
          k[d]++;
          pops[d]++;
        end
        if (iss[d] - pops[d] > occ_max[d]) occ_max[d] = iss[d] - pops[d];
        if (done[d]) begin
          nd[d]++;
          dc[d] = c;
        end
      end
      fin = (dc[0] >= 0) && (dc[1] >= 0);
      @(posedge clk); #1;
    end
    check("burst_timeout", fin, 1);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("cmd_ready_after_done", cmd_ready[d], 1);
      check("busy_after_done", busy[d], 0);
      check("word_count", k[d], b.len);
      check("issue_count", iss[d], b.len);
      check("done_pulses", nd[d], 1);
      check("occupancy_bound", occ_max[d] <= lat_of(d) + 1, 1);
      if (b.len == 0) begin
        check("zero_len_no_valid", fv[d], -1);
        check("zero_len_done_cycle", dc[d], 2);
      end else begin
        check("first_valid_cycle", fv[d], 2 + lat_of(d));
        check("done_after_last", dc[d], lhs[d] + 1);
        check("first_word", first_d[d], b.first);
        check("last_word", last_d[d], b.last);
        if (b.rdy == 16'hFFFF) check("throughput", lhs[d], fv[d] + b.len - 1);
      end
    end
  endtask

  burst_t vec[6];
  burst_t post_rst;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    for (int i = 0; i < 64; i++) mem[i] = DW'(i);
    vec[0] = '{addr: 6'd5,  len: 4,  rdy: 16'hFFFF,              first: 5,  last: 8};
    vec[1] = '{addr: 6'd62, len: 4,  rdy: 16'hFFFF,              first: 62, last: 1};
    vec[2] = '{addr: 6'd9,  len: 0,  rdy: 16'hFFFF,              first: 0,  last: 0};
    vec[3] = '{addr: 6'd33, len: 16, rdy: 16'b1001_0110_1001_1001, first: 33, last: 48};
    vec[4] = '{addr: 6'd50, len: 64, rdy: 16'hFFFF,              first: 50, last: 49};
    vec[5] = '{addr: 6'd7,  len: 5,  rdy: 16'h8421,              first: 7,  last: 11};
    post_rst = '{addr: 6'd0, len: 2, rdy: 16'hFFFF, first: 0, last: 1};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b0;
`ifdef FPGA_SDPRAM_RD_STREAM_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_burst(vec[i]);

    // Reset mid-burst, then an immediate new burst while stale returns are in flight.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = 6'd20; cmd_len = LW'(10); m_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 50 && seen < 3; c++) begin
      @(negedge clk);
      if (m_valid[0]) seen++;
    end
    check("pre_reset_words", seen, 3);
    #2 rst_n = 1'b0;
    #1 check_reset("async_reset");
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_burst(post_rst);

`ifdef FPGA_SDPRAM_RD_STREAM_ABORT_EN
    begin
      int nd[2];
      bit saw_valid, saw_last;
      nd[0] = 0; nd[1] = 0; saw_valid = 1'b0; saw_last = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_addr = 6'd30; cmd_len = LW'(8); m_ready = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 abort = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) check("abort_stops_issue", ram_rd[d], 0);
      @(posedge clk); #1;
      abort = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) check("abort_flush_valid", m_valid[d], 0);
      for (int c = 0; c < 30; c++) begin
        for (int d = 0; d < 2; d++) begin
          if (m_valid[d]) saw_valid = 1'b1;
          if (m_last[d]) saw_last = 1'b1;
          if (done[d]) nd[d]++;
        end
        @(negedge clk);
      end
      check("abort_no_valid", saw_valid, 0);
      check("abort_no_last", saw_last, 0);
      for (int d = 0; d < 2; d++) check("abort_done_pulses", nd[d], 1);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) check("abort_idle_ignored", busy[d], 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
